// File: rtl/key_pkg.sv
// Shared definitions for the key debounce/capture stage: state encoding and
// synchroniser depth.
package key_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        StIdle        = ST_IDLE,
        StPressWait   = ST_PRESS_WAIT,
        StHeld        = ST_HELD,
        StReleaseWait = ST_RELEASE_WAIT
    } key_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for asynchronous inputs; resets to all-zero.
module sync_2ff
    import key_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_debounce_capture.sv
// Synchronises and debounces a push-button, emitting one pulse per accepted
// press together with the switch value sampled at that press.
module key_debounce_capture
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          KEY_ACTIVE_LOW  = 1'b0,
    parameter int unsigned DATA_W          = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              k,
    input  logic [DATA_W-1:0] in,
    output logic              k_pulse,
    output logic              k_level,
    output logic [DATA_W-1:0] operand
);

    localparam int unsigned    CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic              k_norm;
    logic              k_s;
    logic [DATA_W-1:0] in_s;

    key_state_e        state_q;
    logic [CntW-1:0]   cnt_q;
    logic              k_pulse_q;
    logic              k_level_q;
    logic [DATA_W-1:0] operand_q;

    // Normalise polarity so everything downstream treats 1 as pressed.
    assign k_norm = KEY_ACTIVE_LOW ? ~k : k;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync_k (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (k_norm),
        .q_o    (k_s)
    );

    sync_2ff #(
        .WIDTH (DATA_W)
    ) u_sync_in (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (in),
        .q_o    (in_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            k_pulse_q <= 1'b0;
            k_level_q <= 1'b0;
            operand_q <= '0;
        end else begin
            k_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (k_s) begin
                        state_q <= StPressWait;
                        cnt_q   <= '0;
                    end
                end
                StPressWait: begin
                    if (!k_s) begin
                        state_q <= StIdle;
                    end else if (cnt_q == CntMax) begin
                        state_q   <= StHeld;
                        k_pulse_q <= 1'b1;
                        k_level_q <= 1'b1;
                        operand_q <= in_s;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StHeld: begin
                    if (!k_s) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= '0;
                    end
                end
                StReleaseWait: begin
                    // A brief return to 1 is bounce: back to HELD with no new pulse.
                    if (k_s) begin
                        state_q <= StHeld;
                    end else if (cnt_q == CntMax) begin
                        state_q   <= StIdle;
                        k_level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
            endcase
        end
    end

    assign k_pulse = k_pulse_q;
    assign k_level = k_level_q;
    assign operand = operand_q;

endmodule
